regbank_arbiter: RTL

//  Round-robin arbiter and sequencer sharing one 16x16 register bank among NUM_REQ requesters.

---
 rtl/regbank_arbiter_if.sv | 37 +++
 rtl/regbank_arbiter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/regbank_arbiter_if.sv
// Requester-side and bank-side signal bundle for regbank_arbiter.
interface regbank_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned DATA_W  = 16
);
  // Requester command and completion signals
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      busy;

  // Single-port register bank signals
  logic                      bank_write_en;
  logic                      bank_read_en;
  logic [ADDR_W-1:0]         bank_addr;
  logic [DATA_W-1:0]         bank_data_in;
  logic [DATA_W-1:0]         bank_data_out;

  // Arbiter side
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, bank_data_out,
    output req_ready, rsp_valid, rsp_rdata, busy,
           bank_write_en, bank_read_en, bank_addr, bank_data_in
  );

  // Requester / bank side
  modport master (
    output req_valid, req_write, req_addr, req_wdata, bank_data_out,
    input  req_ready, rsp_valid, rsp_rdata, busy,
           bank_write_en, bank_read_en, bank_addr, bank_data_in
  );
endinterface

// File: rtl/regbank_arbiter.sv
// Round-robin arbiter sequencing one command at a time onto a shared single-port register bank.
module regbank_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  regbank_arbiter_if.slave  bus
);
  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t              r_state, w_state_nxt;
  logic [IDX_W-1:0]    r_gnt, w_gnt_nxt;
  logic [IDX_W-1:0]    r_last, w_last_nxt;
  logic                r_write, w_write_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;

  logic [NUM_REQ-1:0]  r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_W-1:0]   r_rsp_rdata, w_rsp_rdata_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_bank_we, w_bank_we_nxt;
  logic                r_bank_re, w_bank_re_nxt;
  logic [ADDR_W-1:0]   r_bank_addr, w_bank_addr_nxt;
  logic [DATA_W-1:0]   r_bank_din, w_bank_din_nxt;

  logic [NUM_REQ-1:0]  w_ready;
  logic                w_found;
  logic [IDX_W-1:0]    w_sel;

  // State register plus latched command and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_gnt       <= '0;
      r_last      <= IDX_W'(NUM_REQ - 1);
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cnt       <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_busy      <= 1'b0;
      r_bank_we   <= 1'b0;
      r_bank_re   <= 1'b0;
      r_bank_addr <= '0;
      r_bank_din  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_last      <= w_last_nxt;
      r_write     <= w_write_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_busy      <= w_busy_nxt;
      r_bank_we   <= w_bank_we_nxt;
      r_bank_re   <= w_bank_re_nxt;
      r_bank_addr <= w_bank_addr_nxt;
      r_bank_din  <= w_bank_din_nxt;
    end
  end

  // Round-robin pick, next-state sequencing and next values of the registered outputs
  always_comb begin
    int unsigned v_idx;
    int unsigned v_abase;
    int unsigned v_dbase;
    w_state_nxt     = r_state;
    w_gnt_nxt       = r_gnt;
    w_last_nxt      = r_last;
    w_write_nxt     = r_write;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    w_cnt_nxt       = r_cnt;
    w_ready         = '0;
    w_rsp_rdata_nxt = '0;
    w_found         = 1'b0;
    w_sel           = '0;
    v_idx           = 0;

    // First valid requester after the last one granted, wrapping around
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      v_idx = (32'(r_last) + k) % NUM_REQ;
      if (!w_found && bus.req_valid[IDX_W'(v_idx)]) begin
        w_found = 1'b1;
        w_sel   = IDX_W'(v_idx);
      end
    end
    v_abase = 32'(w_sel) * ADDR_W;
    v_dbase = 32'(w_sel) * DATA_W;

    case (r_state)
      S_IDLE: begin
        if (w_found && !rst) begin
          w_ready[w_sel] = 1'b1;
          w_gnt_nxt      = w_sel;
          w_last_nxt     = w_sel;
          w_write_nxt    = bus.req_write[w_sel];
          w_addr_nxt     = bus.req_addr[v_abase +: ADDR_W];
          w_wdata_nxt    = bus.req_wdata[v_dbase +: DATA_W];
          w_state_nxt    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_cnt_nxt   = CNT_W'(RD_LATENCY - 1);
        w_state_nxt = r_write ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_rsp_rdata_nxt = bus.bank_data_out;
          w_state_nxt     = S_RESP;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt      = (w_state_nxt != S_IDLE);
    w_bank_we_nxt   = (w_state_nxt == S_ISSUE) && w_write_nxt;
    w_bank_re_nxt   = (w_state_nxt == S_ISSUE) && !w_write_nxt;
    w_bank_addr_nxt = w_busy_nxt ? w_addr_nxt : '0;
    w_bank_din_nxt  = w_busy_nxt ? w_wdata_nxt : '0;
    w_rsp_valid_nxt = (w_state_nxt == S_RESP) ?
                      ({{(NUM_REQ-1){1'b0}}, 1'b1} << w_gnt_nxt) : '0;
  end

  assign bus.req_ready     = w_ready;
  assign bus.rsp_valid     = r_rsp_valid;
  assign bus.rsp_rdata     = r_rsp_rdata;
  assign bus.busy          = r_busy;
  assign bus.bank_write_en = r_bank_we;
  assign bus.bank_read_en  = r_bank_re;
  assign bus.bank_addr     = r_bank_addr;
  assign bus.bank_data_in  = r_bank_din;
endmodule
